// File: rtl/neuron_mac_gen.sv
// neuron_mac_gen
// One runtime-addressable neuron. Weights are streamed in through a wrapping
// write pointer and the bias through a single register; both can be loaded
// only while idle and only when (cfg_layer, cfg_neuron) selects this instance.
// Inputs arrive LANES elements per beat. The datapath is a two-stage signed
// multiply-accumulate with saturation on every add, followed by a bias add,
// a right shift back to the DATA_W fixed-point format, a clamp to DATA_W,
// and an optional ReLU.
//
// Optional build macro: NEURON_SAT_FLAG_EN adds the sat_flag output, a sticky
// OR of every accumulator or output clamp of the current result.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_layer/neuron    runtime select for weight/bias writes
//   w_valid, w_data     weight write strobe and value
//   b_valid, b_data     bias write strobe and value
//   in_valid/in_ready   input beat handshake, lane k at in_data[k*DATA_W +: DATA_W]
//   out_valid/out_ready result handshake, out_data = activated result
//   sat_flag            (NEURON_SAT_FLAG_EN only) clamp indicator
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. out_valid, once raised, stays high with out_data unchanged
// until that transfer. in_ready is high in IDLE (unless a weight or bias
// write is accepted in the same cycle) and in ACCUM, and low elsewhere.
//
// The FSM state is visible on the internal signal 'state'.
module neuron_mac_gen #(
  parameter int DATA_W     = 16,
  parameter int FRAC       = 8,
  parameter int NUM_WEIGHT = 8,
  parameter int LANES      = 2,
  parameter int LAYER_ID   = 1,
  parameter int NEURON_ID  = 0,
  parameter int ACT_RELU   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               cfg_layer,
  input  logic [31:0]               cfg_neuron,
  input  logic                      w_valid,
  input  logic [DATA_W-1:0]         w_data,
  input  logic                      b_valid,
  input  logic [DATA_W-1:0]         b_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data
`ifdef NEURON_SAT_FLAG_EN
  ,
  output logic                      sat_flag
`endif
);

  localparam int BEATS = NUM_WEIGHT / LANES;
  localparam int PW    = 2 * DATA_W;                 // product / accumulator width
  localparam int SW    = PW + $clog2(LANES + 1);     // lane-sum width before clamp
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;

  localparam logic [CW-1:0]     LAST_BEAT = CW'(BEATS - 1);
  localparam logic [AW-1:0]     LAST_W    = AW'(NUM_WEIGHT - 1);
  localparam logic [PW-1:0]     MAX_PW    = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0]     MIN_PW    = {1'b1, {(PW-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_D     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_D     = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_BIAS,
    S_OUT
  } state_t;

  state_t                    state;
  logic [CW-1:0]             beat_cnt;
  logic                      flush_cnt;
  logic [AW-1:0]             w_ptr;
  logic signed [DATA_W-1:0]  weight_mem [NUM_WEIGHT];
  logic signed [DATA_W-1:0]  bias_reg;
  logic signed [PW-1:0]      acc;
  logic signed [PW-1:0]      prod [LANES];
  logic                      prod_valid;

  // Select, writes and input handshake
  logic sel;
  logic w_wr;
  logic b_wr;
  logic beat_fire;

  assign sel       = (cfg_layer == LAYER_ID) && (cfg_neuron == NEURON_ID);
  assign w_wr      = w_valid && sel && (state == S_IDLE);
  assign b_wr      = b_valid && sel && (state == S_IDLE);
  // A configuration write in IDLE steals the cycle from the input port.
  assign in_ready  = !rst && (((state == S_IDLE) && !w_wr && !b_wr) || (state == S_ACCUM));
  assign beat_fire = in_valid && in_ready;

  // Lane operands: beat j, lane k multiplies weight[j*LANES+k]
  logic signed [PW-1:0] lane_x [LANES];
  logic signed [PW-1:0] lane_w [LANES];

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_x[k] = {{(PW-DATA_W){in_data[k*DATA_W + DATA_W - 1]}}, in_data[k*DATA_W +: DATA_W]};
      lane_w[k] = {{(PW-DATA_W){weight_mem[AW'(int'(beat_cnt) * LANES + k)][DATA_W-1]}},
                   weight_mem[AW'(int'(beat_cnt) * LANES + k)]};
    end
  end

  // Stage 2: lanes plus accumulator, clamped to PW bits
  logic [SW-1:0] sum_wide;
  logic          sum_fit;
  logic [PW-1:0] sum_sat;

  always_comb begin
    sum_wide = {{(SW-PW){acc[PW-1]}}, acc};
    for (int k = 0; k < LANES; k++) begin
      sum_wide = sum_wide + {{(SW-PW){prod[k][PW-1]}}, prod[k]};
    end
    // Fits when every bit from PW-1 upward agrees with the sign.
    sum_fit = (&sum_wide[SW-1:PW-1]) || !(|sum_wide[SW-1:PW-1]);
    sum_sat = sum_fit ? sum_wide[PW-1:0] : (sum_wide[SW-1] ? MIN_PW : MAX_PW);
  end

  // Bias aligned to the accumulator's 2*FRAC fractional bits
  logic [PW-1:0] bias_ext;
  logic [PW:0]   bias_sum;
  logic          bias_fit;
  logic [PW-1:0] bias_sat;

  always_comb begin
    bias_ext = {{(PW-DATA_W){bias_reg[DATA_W-1]}}, bias_reg} << FRAC;
    bias_sum = {acc[PW-1], acc} + {bias_ext[PW-1], bias_ext};
    bias_fit = (bias_sum[PW] == bias_sum[PW-1]);
    bias_sat = bias_fit ? bias_sum[PW-1:0] : (bias_sum[PW] ? MIN_PW : MAX_PW);
  end

  // Output: back to FRAC fractional bits, clamp, activation
  logic signed [PW-1:0] acc_shr;
  logic                 out_fit;
  logic [DATA_W-1:0]    r_sat;
  logic [DATA_W-1:0]    act_val;

  always_comb begin
    acc_shr = acc >>> FRAC;
    out_fit = (&acc_shr[PW-1:DATA_W-1]) || !(|acc_shr[PW-1:DATA_W-1]);
    r_sat   = out_fit ? acc_shr[DATA_W-1:0] : (acc_shr[PW-1] ? MIN_D : MAX_D);
    act_val = ((ACT_RELU != 0) && r_sat[DATA_W-1]) ? '0 : r_sat;
  end

  // Weight memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr) weight_mem[w_ptr] <= w_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      flush_cnt  <= 1'b0;
      w_ptr      <= '0;
      bias_reg   <= '0;
      acc        <= '0;
      prod_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      for (int k = 0; k < LANES; k++) prod[k] <= '0;
    end else begin
      // Stage 1: register the lane products of every accepted beat
      prod_valid <= beat_fire;
      if (beat_fire) begin
        for (int k = 0; k < LANES; k++) prod[k] <= lane_x[k] * lane_w[k];
      end

      if (w_wr) w_ptr <= (w_ptr == LAST_W) ? '0 : w_ptr + 1'b1;
      if (b_wr) bias_reg <= b_data;

      // Stage 2 runs one cycle behind each accepted beat (ACCUM or first FLUSH cycle).
      if (prod_valid) acc <= sum_sat;

      case (state)
        S_IDLE: begin
          if (beat_fire) begin
            acc <= '0;
            if (BEATS == 1) begin
              state     <= S_FLUSH;
              flush_cnt <= 1'b0;
            end else begin
              state    <= S_ACCUM;
              beat_cnt <= CW'(1);
            end
          end
        end
        S_ACCUM: begin
          if (beat_fire) begin
            if (beat_cnt == LAST_BEAT) begin
              state     <= S_FLUSH;
              flush_cnt <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // Two cycles: last products land in stage 1, then in the accumulator.
          flush_cnt <= 1'b1;
          if (flush_cnt) state <= S_BIAS;
        end
        S_BIAS: begin
          acc   <= bias_sat;
          state <= S_OUT;
        end
        S_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= act_val;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            beat_cnt  <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NEURON_SAT_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if ((state == S_OUT) && out_valid && out_ready) begin
      sat_flag <= 1'b0;
    end else begin
      if (prod_valid && !sum_fit) sat_flag <= 1'b1;
      if ((state == S_BIAS) && !bias_fit) sat_flag <= 1'b1;
      if ((state == S_OUT) && !out_valid && !out_fit) sat_flag <= 1'b1;
    end
  end
`endif

endmodule
